ifft_butterfly_pipe: RTL and testbench

- Pipelined radix-2 decimation-in-frequency butterfly for the inverse FFT path.
- Accepts one complex pair plus its forward-FFT twiddle per handshake. It conjugates the twiddle internally and produces the inverse butterfly outputs, scaled by 1/2 to give the 1/N normalisation over log2(N) stages.
- Sits in the IFFT datapath as the reverse-direction counterpart of the forward DIT butterfly array, reusing the same Q1.15 twiddle ROM values.
- Has a valid/ready handshake on both sides, so it can be chained stage-to-stage or fed from the sample memory sequencer.

---
 rtl/ifft_butterfly_pipe.sv | 107 ++++++++++
 tb/tb_ifft_butterfly_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_butterfly_pipe.sv
// ifft_butterfly_pipe: three-stage radix-2 inverse DIF butterfly using conj(w), scaled by 1/2, valid/ready flow control
module ifft_butterfly_pipe #(
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  in_a_re,
    input  logic signed [15:0]  in_a_im,
    input  logic signed [15:0]  in_b_re,
    input  logic signed [15:0]  in_b_im,
    input  logic signed [15:0]  tw_re,
    input  logic signed [15:0]  tw_im,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [15:0]  out_1_re,
    output logic signed [15:0]  out_1_im,
    output logic signed [15:0]  out_2_re,
    output logic signed [15:0]  out_2_im,
    output logic [TAG_W-1:0]    out_tag,
    output logic                sat_flag,
    input  logic                sat_clear
);
    logic                en;
    logic                v1, v2;
    logic signed [16:0]  s1_sre, s1_sim, s1_dre, s1_dim;
    logic signed [15:0]  s1_wre, s1_wim;
    logic [TAG_W-1:0]    t1, t2;
    logic signed [32:0]  p1, p2, p3, p4;
    logic signed [16:0]  s2_sre, s2_sim;
    logic signed [33:0]  acc_re, acc_im, sh_re, sh_im;
    logic                hi_re, lo_re, hi_im, lo_im, clip;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        acc_re = 34'(p1) + 34'(p2) + 34'sd32768;
        acc_im = 34'(p3) - 34'(p4) + 34'sd32768;
        sh_re  = acc_re >>> 16;
        sh_im  = acc_im >>> 16;
        hi_re  = sh_re > 34'sd32767;
        lo_re  = sh_re < -34'sd32768;
        hi_im  = sh_im > 34'sd32767;
        lo_im  = sh_im < -34'sd32768;
        clip   = hi_re | lo_re | hi_im | lo_im;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1_sre    <= '0;
            s1_sim    <= '0;
            s1_dre    <= '0;
            s1_dim    <= '0;
            s1_wre    <= '0;
            s1_wim    <= '0;
            t1        <= '0;
            t2        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            p4        <= '0;
            s2_sre    <= '0;
            s2_sim    <= '0;
            out_1_re  <= '0;
            out_1_im  <= '0;
            out_2_re  <= '0;
            out_2_im  <= '0;
            out_tag   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (en) begin
                v1        <= in_valid;
                s1_sre    <= 17'(in_a_re) + 17'(in_b_re);
                s1_sim    <= 17'(in_a_im) + 17'(in_b_im);
                s1_dre    <= 17'(in_a_re) - 17'(in_b_re);
                s1_dim    <= 17'(in_a_im) - 17'(in_b_im);
                s1_wre    <= tw_re;
                s1_wim    <= tw_im;
                t1        <= in_tag;
                v2        <= v1;
                p1        <= 33'(s1_dre) * 33'(s1_wre);
                p2        <= 33'(s1_dim) * 33'(s1_wim);
                p3        <= 33'(s1_dim) * 33'(s1_wre);
                p4        <= 33'(s1_dre) * 33'(s1_wim);
                s2_sre    <= s1_sre;
                s2_sim    <= s1_sim;
                t2        <= t1;
                out_valid <= v2;
                out_1_re  <= 16'((s2_sre + 17'sd1) >>> 1);
                out_1_im  <= 16'((s2_sim + 17'sd1) >>> 1);
                out_2_re  <= hi_re ? 16'sh7fff : lo_re ? 16'sh8000 : sh_re[15:0];
                out_2_im  <= hi_im ? 16'sh7fff : lo_im ? 16'sh8000 : sh_im[15:0];
                out_tag   <= t2;
            end
            if (en && v2 && clip)
                sat_flag <= 1'b1;
            else if (sat_clear)
                sat_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// tb_ifft_butterfly_pipe: directed-vector bench for the inverse butterfly pipeline
module tb_ifft_butterfly_pipe;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic signed [15:0] tw_re = '0, tw_im = '0;
    logic [7:0]         in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_1_re, out_1_im, out_2_re, out_2_im;
    logic [7:0]         out_tag;
    logic               sat_flag;
    logic               sat_clear = 1'b0;
    int                 total = 0;
    int                 bad = 0;

    ifft_butterfly_pipe #(.TAG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .tw_re(tw_re), .tw_im(tw_im), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_1_re(out_1_re), .out_1_im(out_1_im), .out_2_re(out_2_re), .out_2_im(out_2_im),
        .out_tag(out_tag), .sat_flag(sat_flag), .sat_clear(sat_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stream vector i: a=(1000i,100i), b=(200,-300), w=-j so conj(w)=+j.
    // Hand derivation: out_1=(500i+100, 50i-150), out_2=j*(a-b)/2=(-50i-150, 500i-100).
    task automatic drive_pair(input int i);
        in_a_re = 16'(1000 * i);
        in_a_im = 16'(100 * i);
        in_b_re = 16'sd200;
        in_b_im = -16'sd300;
        tw_re   = 16'sd0;
        tw_im   = 16'sh8000;
        in_tag  = 8'(i);
    endtask

    function automatic logic [63:0] exp_of(input int i);
        return {16'(500 * i + 100), 16'(50 * i - 150), 16'(-50 * i - 150), 16'(500 * i - 100)};
    endfunction

    task automatic test_reset;
        out_ready = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: out_valid=%b sat_flag=%b want 0 0", out_valid, sat_flag);
        end
        total++;
        if ({out_1_re, out_1_im, out_2_re, out_2_im, out_tag} !== 72'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {out_1_re, out_1_im, out_2_re, out_2_im, out_tag});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_basic;
        in_a_re = 16'sd16384; in_a_im = 16'sd0; in_b_re = 16'sd8192; in_b_im = 16'sd0;
        tw_re = 16'sd32767; tw_im = 16'sd0; in_tag = 8'h5a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 8'h5a) begin
            bad++;
            $display("FAIL basic_valid_tag: valid=%b tag=%h want 1 5a", out_valid, out_tag);
        end
        total++;
        if ({out_1_re, out_1_im, out_2_re, out_2_im} !== {16'sd12288, 16'sd0, 16'sd4096, 16'sd0}) begin
            bad++;
            $display("FAIL basic_data: got %0d %0d %0d %0d want 12288 0 4096 0", out_1_re, out_1_im, out_2_re, out_2_im);
        end
        total++;
        if (sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL basic_sat: got %b want 0", sat_flag);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_single: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_conj;
        in_a_re = 16'sd16384; in_a_im = 16'sd0; in_b_re = 16'sd8192; in_b_im = 16'sd0;
        tw_re = 16'sd0; tw_im = 16'sh8000; in_tag = 8'hc3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 8'hc3) begin
            bad++;
            $display("FAIL conj_valid_tag: valid=%b tag=%h want 1 c3", out_valid, out_tag);
        end
        total++;
        if ({out_1_re, out_1_im, out_2_re, out_2_im} !== {16'sd12288, 16'sd0, 16'sd0, 16'sd4096}) begin
            bad++;
            $display("FAIL conj_data: got %0d %0d %0d %0d want 12288 0 0 4096", out_1_re, out_1_im, out_2_re, out_2_im);
        end
    endtask

    task automatic test_saturation;
        in_a_re = 16'sd32767; in_a_im = 16'sd32767; in_b_re = 16'sh8000; in_b_im = 16'sh8000;
        tw_re = 16'sh8000; tw_im = 16'sh8000; in_tag = 8'h77; in_valid = 1'b1;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 8'h77) begin
            bad++;
            $display("FAIL sat_valid_tag: valid=%b tag=%h want 1 77", out_valid, out_tag);
        end
        total++;
        if ({out_1_re, out_1_im, out_2_re, out_2_im} !== {16'sd0, 16'sd0, 16'sh8000, 16'sd0}) begin
            bad++;
            $display("FAIL sat_data: got %0d %0d %0d %0d want 0 0 -32768 0", out_1_re, out_1_im, out_2_re, out_2_im);
        end
        total++;
        if (sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_set_wins: got %b want 1", sat_flag);
        end
        sat_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_sticky: got %b want 1", sat_flag);
        end
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        total++;
        if (sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL sat_clear: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit acc;
        bit prev_stall = 1'b0;
        logic [71:0] prev_out = '0;
        bit saw_drop = 1'b0;
        while (got < 10 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = sent < 10;
            if (cyc >= 4 && cyc <= 8) begin
                in_a_re = 16'sd12345; in_a_im = -16'sd777; in_b_re = 16'sd4321;
                in_b_im = 16'sd999; tw_re = 16'sd1234; tw_im = 16'sd5678; in_tag = 8'hee;
            end else if (sent < 10)
                drive_pair(sent);
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready cyc %0d: got %b want 0", cyc, in_ready);
                end
                saw_drop = 1'b1;
            end
            if (prev_stall) begin
                total++;
                if ({out_1_re, out_1_im, out_2_re, out_2_im, out_tag} !== prev_out) begin
                    bad++;
                    $display("FAIL bp_hold cyc %0d: got %h want %h", cyc, {out_1_re, out_1_im, out_2_re, out_2_im, out_tag}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_tag !== 8'(got) || {out_1_re, out_1_im, out_2_re, out_2_im} !== exp_of(got)) begin
                    bad++;
                    $display("FAIL bp_result %0d: tag=%0d data=%h want tag=%0d data=%h", got, out_tag, {out_1_re, out_1_im, out_2_re, out_2_im}, got, exp_of(got));
                end
                got++;
            end
            acc        = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_1_re, out_1_im, out_2_re, out_2_im, out_tag};
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 10 || !saw_drop) begin
            bad++;
            $display("FAIL bp_count: results=%0d stall_seen=%0d want 10 1", got, saw_drop);
        end
    endtask

    task automatic test_full_rate;
        int got = 0;
        bit exp_v;
        out_ready = 1'b1;
        drive_pair(0);
        in_valid = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e < 16) drive_pair(e);
            else in_valid = 1'b0;
            exp_v = e >= 3 && e <= 18;
            total++;
            if (out_valid !== exp_v) begin
                bad++;
                $display("FAIL full_valid edge %0d: got %b want %b", e, out_valid, exp_v);
            end
            if (exp_v && out_valid) begin
                total++;
                if (out_tag !== 8'(e - 3) || {out_1_re, out_1_im, out_2_re, out_2_im} !== exp_of(e - 3)) begin
                    bad++;
                    $display("FAIL full_result edge %0d: tag=%0d data=%h want tag=%0d data=%h", e, out_tag, {out_1_re, out_1_im, out_2_re, out_2_im}, e - 3, exp_of(e - 3));
                end
                got++;
            end
        end
        total++;
        if (got != 16) begin
            bad++;
            $display("FAIL full_count: got %0d want 16", got);
        end
    endtask

    task automatic test_reset_midstream;
        bit stale = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_pair(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || {out_1_re, out_1_im, out_2_re, out_2_im, out_tag} !== 72'd0) begin
            bad++;
            $display("FAIL mid_reset_clear: valid=%b data=%h want 0 0", out_valid, {out_1_re, out_1_im, out_2_re, out_2_im, out_tag});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL mid_reset_stale: out_valid seen 1 want 0");
        end
        drive_pair(4);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 8'd4 || {out_1_re, out_1_im, out_2_re, out_2_im} !== exp_of(4)) begin
            bad++;
            $display("FAIL mid_reset_next: valid=%b tag=%0d data=%h want 1 4 %h", out_valid, out_tag, {out_1_re, out_1_im, out_2_re, out_2_im}, exp_of(4));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_conj;
        test_saturation;
        test_back_to_back;
        test_full_rate;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
